dmem_dump_arbiter: RTL

- Owns the single port of the data memory in the MEM stage and shares it between two requesters: the pipeline MEM stage and a debug dump sequencer.
- The debug unit pulses a start request. The block then takes the memory, walks word addresses 0..2^DEPTH_BITS-1, and streams each word out over a valid/ready handshake toward the UART transmit side.
- While the dump owns the memory, the pipeline is stalled and its writes are blocked.

---
 rtl/dmem_dump_arbiter_pkg.sv | 17 +
 rtl/dmem_dump_arbiter_if.sv | 47 ++++
 rtl/dmem_dump_arbiter_port_mux.sv | 32 +++
 rtl/dmem_dump_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/dmem_dump_arbiter_pkg.sv
// Shared definitions for the data-memory dump arbiter and the MEM stage.
// Holds the dump FSM encoding and the memory-bus control bit positions.
package dmem_dump_arbiter_pkg;

  typedef logic [1:0] dump_state_t;

  localparam dump_state_t ST_IDLE = 2'd0;
  localparam dump_state_t ST_READ = 2'd1;
  localparam dump_state_t ST_SEND = 2'd2;
  localparam dump_state_t ST_DONE = 2'd3;

  // Bit positions inside the MEM-stage control bus.
  localparam int MEM_BUS_WRITE_BIT  = 0;
  localparam int MEM_BUS_READ_BIT   = 1;
  localparam int MEM_BUS_BRANCH_BIT = 2;

endpackage

// File: rtl/dmem_dump_arbiter_if.sv
// Bundle of the pipeline, dump-stream and data-memory signals around the arbiter.
// master is the arbiter's view; slave is the surrounding pipeline/memory/debug side.
interface dmem_dump_arbiter_if #(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  pipe_write;
  logic                  pipe_read;
  logic [ADDR_BITS-1:0]  pipe_addr;
  logic [DATA_WIDTH-1:0] pipe_wdata;
  logic [DATA_WIDTH-1:0] pipe_rdata;
  logic                  pipe_stall;

  logic                  dump_start;
  logic                  dump_abort;
  logic                  dump_ready;
  logic                  dump_valid;
  logic [DATA_WIDTH-1:0] dump_data;
  logic [ADDR_BITS-1:0]  dump_addr;
  logic                  dump_busy;
  logic                  dump_done;

  logic                  mem_write;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  pipe_write, pipe_read, pipe_addr, pipe_wdata,
    input  dump_start, dump_abort, dump_ready,
    input  mem_rdata,
    output pipe_rdata, pipe_stall,
    output dump_valid, dump_data, dump_addr, dump_busy, dump_done,
    output mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output pipe_write, pipe_read, pipe_addr, pipe_wdata,
    output dump_start, dump_abort, dump_ready,
    output mem_rdata,
    input  pipe_rdata, pipe_stall,
    input  dump_valid, dump_data, dump_addr, dump_busy, dump_done,
    input  mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_dump_arbiter_port_mux.sv
// Combinational ownership mux for the single data-memory port.
// While the dump owns the port, pipeline writes are dropped and its read data is zeroed.
module dmem_port_mux #(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  dump_owns,
  input  logic [ADDR_BITS-1:0]  dump_mem_addr,
  input  logic                  pipe_write,
  input  logic [ADDR_BITS-1:0]  pipe_addr,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  output logic [DATA_WIDTH-1:0] pipe_rdata,
  output logic                  mem_write,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  always_comb begin
    mem_addr   = pipe_addr;
    mem_wdata  = pipe_wdata;
    mem_write  = pipe_write;
    pipe_rdata = mem_rdata;
    if (dump_owns) begin
      mem_addr   = dump_mem_addr;
      mem_wdata  = '0;
      mem_write  = 1'b0;
      pipe_rdata = '0;
    end
  end

endmodule

// File: rtl/dmem_dump_arbiter.sv
// Shares the MEM-stage data memory port between the pipeline and a debug dump
// sequencer that streams every word out over a valid/ready handshake.
module dmem_dump_arbiter
  import dmem_dump_arbiter_pkg::*;
#(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_BITS = 5
) (
  input logic               clk,
  input logic               rst_n,
  dmem_dump_arbiter_if.master bus
);

  localparam logic [DEPTH_BITS-1:0] LAST_IDX = '1;

  dump_state_t           state;
  logic [DEPTH_BITS-1:0] idx;
  logic                  dump_valid;
  logic [DATA_WIDTH-1:0] dump_data;
  logic [ADDR_BITS-1:0]  dump_addr;
  logic                  dump_done;
  logic                  dump_owns;

  // Ownership follows the registered state only, so pipe_stall also drops with reset.
  assign dump_owns = (state != ST_IDLE);

  dmem_port_mux #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_mux (
    .dump_owns    (dump_owns),
    .dump_mem_addr(ADDR_BITS'(idx)),
    .pipe_write   (bus.pipe_write),
    .pipe_addr    (bus.pipe_addr),
    .pipe_wdata   (bus.pipe_wdata),
    .pipe_rdata   (bus.pipe_rdata),
    .mem_write    (bus.mem_write),
    .mem_addr     (bus.mem_addr),
    .mem_wdata    (bus.mem_wdata),
    .mem_rdata    (bus.mem_rdata)
  );

  // Abort wins over the handshake; idx stops at the last word instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_addr  <= '0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.dump_start) begin
            state <= ST_READ;
            idx   <= '0;
          end
        end
        ST_READ: begin
          if (bus.dump_abort) begin
            state      <= ST_IDLE;
            idx        <= '0;
            dump_valid <= 1'b0;
          end else begin
            dump_data  <= bus.mem_rdata;
            dump_addr  <= ADDR_BITS'(idx);
            dump_valid <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.dump_abort) begin
            state      <= ST_IDLE;
            idx        <= '0;
            dump_valid <= 1'b0;
          end else if (bus.dump_ready) begin
            dump_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state     <= ST_DONE;
              dump_done <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_READ;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          idx        <= '0;
          dump_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pipe_stall = dump_owns;
  assign bus.dump_busy  = dump_owns;
  assign bus.dump_valid = dump_valid;
  assign bus.dump_data  = dump_data;
  assign bus.dump_addr  = dump_addr;
  assign bus.dump_done  = dump_done;

endmodule
